shift_leds: RTL and testbench

- LED chaser: a free-running prescaler counter produces a periodic tick, and each tick rotates a one-hot LED pattern one position.
- The switch inputs enable the chaser, select one of four tick rates and steer the pattern to one of two colour-LED banks.
- Top-level board-facing block; LEDs and switches connect directly to pins.

---
 rtl/shift_leds.sv | 125 ++++++++++++
 tb/tb_shift_leds.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/shift_leds.sv
// shift_leds: LED chaser.
// A free-running prescaler produces a tick at one of four selectable rates.
// Each tick rotates a one-hot LED pattern left by one position.
// The pattern is steered to either the blue or the green LED bank.
module shift_leds #(
    parameter int N_LEDS   = 4,
    parameter int NB_SEL   = 2,
    parameter int NB_COUNT = 14,
    parameter int NB_SW    = 4
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_SW-1:0]  i_sw,
    output logic [N_LEDS-1:0] o_led,
    output logic [N_LEDS-1:0] o_led_b,
    output logic [N_LEDS-1:0] o_led_g
);

    // Rate limits. Each slower rate is the all-ones limit shifted right,
    // so R0 is the counter's all-ones value and the counter can never
    // wrap on its own.
    localparam logic [NB_COUNT-1:0] LIMIT_R0 = {NB_COUNT{1'b1}};
    localparam logic [NB_COUNT-1:0] LIMIT_R1 = LIMIT_R0 >> 1;
    localparam logic [NB_COUNT-1:0] LIMIT_R2 = LIMIT_R0 >> 2;
    localparam logic [NB_COUNT-1:0] LIMIT_R3 = LIMIT_R0 >> 3;

    localparam logic [NB_SEL-1:0] SEL_R0 = NB_SEL'(0);
    localparam logic [NB_SEL-1:0] SEL_R1 = NB_SEL'(1);
    localparam logic [NB_SEL-1:0] SEL_R2 = NB_SEL'(2);

    localparam logic [N_LEDS-1:0]   PATTERN_INIT = {{(N_LEDS-1){1'b0}}, 1'b1};
    localparam logic [NB_COUNT-1:0] COUNT_ZERO   = {NB_COUNT{1'b0}};
    localparam logic [NB_COUNT-1:0] COUNT_ONE    = {{(NB_COUNT-1){1'b0}}, 1'b1};
    localparam logic [N_LEDS-1:0]   LEDS_OFF     = {N_LEDS{1'b0}};

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [N_LEDS-1:0] v);
        return (v != LEDS_OFF) &&
               ((v & (v - {{(N_LEDS-1){1'b0}}, 1'b1})) == LEDS_OFF);
    endfunction

    // Falls back to the reset pattern if the value is not one-hot.
    // This keeps the chaser showing exactly one LED even after an upset.
    function automatic logic [N_LEDS-1:0] onehot_guard(input logic [N_LEDS-1:0] v);
        logic [N_LEDS-1:0] r;
        if (is_onehot(v)) begin
            r = v;
        end else begin
            r = PATTERN_INIT;
        end
        return r;
    endfunction

    logic [NB_COUNT-1:0] counter;
    logic [NB_COUNT-1:0] counter_d;
    logic [N_LEDS-1:0]   pattern_q;
    logic [N_LEDS-1:0]   pattern_d;
    logic [NB_COUNT-1:0] limit_s;
    logic [NB_SEL-1:0]   sel_s;
    logic                enable_s;
    logic                colour_s;
    logic [N_LEDS-1:0]   rotated_s;

    assign sel_s     = i_sw[NB_SEL:1];
    assign enable_s  = i_sw[0];
    assign colour_s  = i_sw[NB_SEL+1];
    assign rotated_s = {pattern_q[N_LEDS-2:0], pattern_q[N_LEDS-1]};

    // Rate-limit select from the switch field.
    always_comb begin
        limit_s = LIMIT_R3;
        case (sel_s)
            SEL_R0:  limit_s = LIMIT_R0;
            SEL_R1:  limit_s = LIMIT_R1;
            SEL_R2:  limit_s = LIMIT_R2;
            default: limit_s = LIMIT_R3;
        endcase
    end

    // Prescaler and pattern next state.
    // The >= compare makes a lowered rate wrap on the next enabled edge.
    always_comb begin
        counter_d = counter;
        pattern_d = pattern_q;
        if (enable_s) begin
            if (counter >= limit_s) begin
                counter_d = COUNT_ZERO;
                pattern_d = onehot_guard(rotated_s);
            end else begin
                counter_d = counter + COUNT_ONE;
                pattern_d = onehot_guard(pattern_q);
            end
        end else begin
            counter_d = counter;
            pattern_d = onehot_guard(pattern_q);
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            counter   <= COUNT_ZERO;
            pattern_q <= PATTERN_INIT;
        end else begin
            counter   <= counter_d;
            pattern_q <= pattern_d;
        end
    end

    // Steer the pattern to one colour bank. Switching banks takes effect
    // in the same cycle.
    always_comb begin
        o_led   = pattern_q;
        o_led_b = LEDS_OFF;
        o_led_g = LEDS_OFF;
        if (colour_s) begin
            o_led_g = pattern_q;
            o_led_b = LEDS_OFF;
        end else begin
            o_led_b = pattern_q;
            o_led_g = LEDS_OFF;
        end
    end

endmodule

// File: tb/tb_shift_leds.sv
// Testbench for shift_leds.
// A reference model pushes the expected counter and pattern values to a
// queue before each clock edge; they are popped and compared after the edge.
module tb_shift_leds;

    localparam int N_LEDS   = 4;
    localparam int NB_SEL   = 2;
    localparam int NB_COUNT = 14;
    localparam int NB_SW    = 4;

    typedef struct packed {
        logic [NB_COUNT-1:0] cnt;
        logic [N_LEDS-1:0]   led;
        logic                col;
    } exp_t;

    logic              clock;
    logic              i_reset;
    logic [NB_SW-1:0]  i_sw;
    logic [N_LEDS-1:0] o_led;
    logic [N_LEDS-1:0] o_led_b;
    logic [N_LEDS-1:0] o_led_g;

    int          checks_cnt = 0;
    int          errors_cnt = 0;
    exp_t        sb_q[$];
    int          m_cnt;
    logic [3:0]  m_pat;

    shift_leds #(
        .N_LEDS  (N_LEDS),
        .NB_SEL  (NB_SEL),
        .NB_COUNT(NB_COUNT),
        .NB_SW   (NB_SW)
    ) dut (
        .clock  (clock),
        .i_reset(i_reset),
        .i_sw   (i_sw),
        .o_led  (o_led),
        .o_led_b(o_led_b),
        .o_led_g(o_led_g)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count one comparison and report it if it does not match.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: advance one clock edge using the current switches.
    task automatic model_step();
        int lim;
        if (i_sw[0]) begin
            lim = (1 << (NB_COUNT - int'(i_sw[2:1]))) - 1;
            if (m_cnt >= lim) begin
                m_cnt = 0;
                m_pat = {m_pat[2:0], m_pat[3]};
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    // Run one clock cycle. The caller is at a falling edge on entry and on
    // exit, so inputs change well away from the rising edge.
    task automatic tick();
        exp_t e;
        model_step();
        e.cnt = m_cnt[NB_COUNT-1:0];
        e.led = m_pat;
        e.col = i_sw[3];
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        check_eq("counter", 32'(dut.counter), 32'(e.cnt));
        check_eq("o_led", 32'(o_led), 32'(e.led));
        check_eq("o_led_b", 32'(o_led_b), e.col ? 32'd0 : 32'(e.led));
        check_eq("o_led_g", 32'(o_led_g), e.col ? 32'(e.led) : 32'd0);
        @(negedge clock);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        m_cnt   = 0;
        m_pat   = 4'b0001;
        i_reset = 1'b1;
        i_sw    = 4'b0111;

        // Reset held with the clock running and the chaser enabled.
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check_eq("rst_counter", 32'(dut.counter), 32'd0);
            check_eq("rst_o_led", 32'(o_led), 32'd1);
            check_eq("rst_o_led_b", 32'(o_led_b), 32'd1);
            check_eq("rst_o_led_g", 32'(o_led_g), 32'd0);
        end
        @(negedge clock);
        i_reset = 1'b0;
        i_sw    = 4'b0000;

        // Disabled: nothing moves.
        ticks(1000);
        check_eq("dis_counter", 32'(dut.counter), 32'd0);
        check_eq("dis_o_led", 32'(o_led), 32'd1);

        // Rate 0: full 16384-cycle period.
        i_sw = 4'b0001;
        ticks(16383);
        check_eq("r0_top_counter", 32'(dut.counter), 32'd16383);
        check_eq("r0_top_o_led", 32'(o_led), 32'b0001);
        tick();
        check_eq("r0_wrap_counter", 32'(dut.counter), 32'd0);
        check_eq("r0_wrap_o_led", 32'(o_led), 32'b0010);

        // Switch to rate 1 at counter 5000; the wrap happens at 8191.
        ticks(5000);
        check_eq("r1_pre_counter", 32'(dut.counter), 32'd5000);
        i_sw = 4'b0011;
        ticks(3191);
        check_eq("r1_top_counter", 32'(dut.counter), 32'd8191);
        check_eq("r1_top_o_led", 32'(o_led), 32'b0010);
        tick();
        check_eq("r1_wrap_counter", 32'(dut.counter), 32'd0);
        check_eq("r1_wrap_o_led", 32'(o_led), 32'b0100);
        ticks(8192);
        check_eq("r1_period_counter", 32'(dut.counter), 32'd0);
        check_eq("r1_period_o_led", 32'(o_led), 32'b1000);

        // Switch to rate 3 at counter 4000, above the new limit.
        ticks(4000);
        check_eq("r3_pre_counter", 32'(dut.counter), 32'd4000);
        i_sw = 4'b0111;
        tick();
        check_eq("r3_wrap_counter", 32'(dut.counter), 32'd0);
        check_eq("r3_wrap_o_led", 32'(o_led), 32'b0001);

        // Colour steer: the green bank takes the pattern in the same cycle.
        i_sw = 4'b1111;
        #1;
        check_eq("col_o_led_g", 32'(o_led_g), 32'(m_pat));
        check_eq("col_o_led_b", 32'(o_led_b), 32'd0);
        check_eq("col_o_led", 32'(o_led), 32'b0001);
        check_eq("col_counter", 32'(dut.counter), 32'(m_cnt));

        ticks(2047);
        check_eq("r3_top_counter", 32'(dut.counter), 32'd2047);
        tick();
        check_eq("r3_period_counter", 32'(dut.counter), 32'd0);
        check_eq("r3_period_o_led_g", 32'(o_led_g), 32'b0010);
        ticks(2048);
        ticks(10);
        check_eq("pre_rst_o_led", 32'(o_led), 32'b0100);
        check_eq("pre_rst_counter", 32'(dut.counter), 32'd10);

        // Asynchronous reset between clock edges.
        #2;
        i_reset = 1'b1;
        #1;
        check_eq("arst_counter", 32'(dut.counter), 32'd0);
        check_eq("arst_o_led", 32'(o_led), 32'b0001);
        m_cnt = 0;
        m_pat = 4'b0001;
        @(negedge clock);
        @(negedge clock);
        i_reset = 1'b0;
        ticks(3);
        check_eq("post_rst_counter", 32'(dut.counter), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
